// File: rtl/spi_globals_pkg.sv
// Shared SPI definitions: bus modes, receive FSM states and the idle chip-select pattern.
package spi_globals_pkg;

   localparam int unsigned CS_MAX_WIDTH = 32;
   localparam logic [CS_MAX_WIDTH-1:0] CS_IDLE = '1;

   typedef enum logic [1:0] {
      CPOL0_CPHA0 = 2'b00,
      CPOL0_CPHA1 = 2'b01,
      CPOL1_CPHA0 = 2'b10,
      CPOL1_CPHA1 = 2'b11
   } spi_mode_e;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } rx_state_e;

   // Modes 0 and 3 sample on the rising sclk edge, modes 1 and 2 on the falling edge.
   function automatic logic samples_on_rise(input spi_mode_e mode);
      return (mode == CPOL0_CPHA0) || (mode == CPOL1_CPHA1);
   endfunction

endpackage

// File: rtl/spi_miso_deserializer_if.sv
// Valid/ready stream carrying paired MISO/MOSI words and their chip-select tag.
interface spi_miso_deserializer_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CS_WIDTH   = 2
);
   logic                  rx_valid;
   logic                  rx_ready;
   logic [DATA_WIDTH-1:0] rx_miso_data;
   logic [DATA_WIDTH-1:0] rx_mosi_data;
   logic [CS_WIDTH-1:0]   rx_cs;

   modport master (
      output rx_valid,
      output rx_miso_data,
      output rx_mosi_data,
      output rx_cs,
      input  rx_ready
   );

   modport slave (
      input  rx_valid,
      input  rx_miso_data,
      input  rx_mosi_data,
      input  rx_cs,
      output rx_ready
   );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer plus one history flop; reports the synchronized level and its edges.
module spi_sync_edge #(
   parameter int unsigned     WIDTH     = 1,
   parameter int unsigned     STAGES    = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             pclk,
   input  logic             areset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0]             hist_q, hist_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], din};
      hist_d = sync_q[STAGES-1];
   end

   always_ff @(posedge pclk or negedge areset) begin
      if (!areset) begin
         sync_q <= {STAGES{RESET_VAL}};
         hist_q <= RESET_VAL;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~hist_q;
   assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_miso_deserializer.sv
// Passive SPI capture: oversamples the serial bus, assembles MISO/MOSI words per frame
// configuration and queues them in a 2-entry valid/ready buffer.
module spi_miso_deserializer
   import spi_globals_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned CS_WIDTH    = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                pclk,
   input  logic                areset,
   input  logic                cpol,
   input  logic                cpha,
   input  logic                lsb_first,
   input  logic                sclk,
   input  logic [CS_WIDTH-1:0] cs,
   input  logic                mosi0,
   input  logic                miso0,
   spi_miso_deserializer_if.master rx,
   output logic                busy,
   output logic                overrun,
   output logic                frame_abort
);

   localparam int unsigned CNT_W    = $clog2(DATA_WIDTH);
   localparam int unsigned SETTLE_W = 2;
   localparam int unsigned FIFO_W   = 2;
   localparam logic [CS_WIDTH-1:0] CS_OFF   = CS_WIDTH'(CS_IDLE);
   localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(DATA_WIDTH - 1);
   localparam logic [SETTLE_W-1:0] SETTLED  = SETTLE_W'(SYNC_STAGES);

   logic                sclk_lvl, sclk_rise, sclk_fall;
   logic [CS_WIDTH-1:0] cs_lvl, cs_rise, cs_fall;
   logic                mosi_lvl, mosi_rise, mosi_fall;
   logic                miso_lvl, miso_rise, miso_fall;
   logic                unused_sync;

   spi_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .pclk(pclk), .areset(areset), .din(sclk),
      .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));

   spi_sync_edge #(.WIDTH(CS_WIDTH), .STAGES(SYNC_STAGES), .RESET_VAL(CS_OFF)) u_sync_cs (
      .pclk(pclk), .areset(areset), .din(cs),
      .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));

   spi_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .pclk(pclk), .areset(areset), .din(mosi0),
      .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

   spi_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_miso (
      .pclk(pclk), .areset(areset), .din(miso0),
      .level(miso_lvl), .rise(miso_rise), .fall(miso_fall));

   assign unused_sync = ^{sclk_lvl, cs_rise, cs_fall, mosi_rise, mosi_fall, miso_rise, miso_fall};

   rx_state_e             state_q, state_d;
   spi_mode_e             mode_q, mode_d;
   logic                  lsb_q, lsb_d;
   logic [CS_WIDTH-1:0]   cs_lat_q, cs_lat_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] sh_miso_q, sh_miso_d, sh_mosi_q, sh_mosi_d;
   logic [SETTLE_W-1:0]   settle_q, settle_d;
   logic                  armed_q, armed_d;
   logic                  busy_q, busy_d;
   logic                  abort_q, abort_d;

   logic [DATA_WIDTH-1:0] nxt_miso, nxt_mosi;
   logic                  sample_edge, push;

   always_comb begin
      nxt_miso = lsb_q ? {miso_lvl, sh_miso_q[DATA_WIDTH-1:1]} : {sh_miso_q[DATA_WIDTH-2:0], miso_lvl};
      nxt_mosi = lsb_q ? {mosi_lvl, sh_mosi_q[DATA_WIDTH-1:1]} : {sh_mosi_q[DATA_WIDTH-2:0], mosi_lvl};
      sample_edge = samples_on_rise(mode_q) ? sclk_rise : sclk_fall;
   end

   // Capture FSM; armed_q holds off capture after reset until cs has been seen idle.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      lsb_d     = lsb_q;
      cs_lat_d  = cs_lat_q;
      bit_cnt_d = bit_cnt_q;
      sh_miso_d = sh_miso_q;
      sh_mosi_d = sh_mosi_q;
      abort_d   = 1'b0;
      push      = 1'b0;
      settle_d  = (settle_q == SETTLED) ? settle_q : settle_q + SETTLE_W'(1);
      armed_d   = armed_q | ((settle_q == SETTLED) && (cs_lvl == CS_OFF));

      case (state_q)
         IDLE: begin
            if (armed_q && (cs_lvl != CS_OFF)) begin
               state_d   = ACTIVE;
               mode_d    = spi_mode_e'({cpol, cpha});
               lsb_d     = lsb_first;
               cs_lat_d  = cs_lvl;
               bit_cnt_d = '0;
            end
         end
         ACTIVE: begin
            if (cs_lvl != cs_lat_q) begin
               state_d = IDLE;
               abort_d = (bit_cnt_q != '0);
            end else if (sample_edge) begin
               sh_miso_d = nxt_miso;
               sh_mosi_d = nxt_mosi;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  push      = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == ACTIVE);
   end

   logic [DATA_WIDTH-1:0] head_miso_q, head_miso_d, head_mosi_q, head_mosi_d;
   logic [DATA_WIDTH-1:0] tail_miso_q, tail_miso_d, tail_mosi_q, tail_mosi_d;
   logic [CS_WIDTH-1:0]   head_cs_q, head_cs_d, tail_cs_q, tail_cs_d;
   logic [FIFO_W-1:0]     fifo_cnt_q, fifo_cnt_d;
   logic                  valid_q, valid_d;
   logic                  overrun_q, overrun_d;
   logic                  pop;

   // Two-entry buffer: head feeds the outputs, tail only fills when head is occupied.
   always_comb begin
      head_miso_d = head_miso_q;
      head_mosi_d = head_mosi_q;
      head_cs_d   = head_cs_q;
      tail_miso_d = tail_miso_q;
      tail_mosi_d = tail_mosi_q;
      tail_cs_d   = tail_cs_q;
      fifo_cnt_d  = fifo_cnt_q;
      overrun_d   = 1'b0;
      pop         = valid_q & rx.rx_ready;

      case ({push, pop})
         2'b01: begin
            head_miso_d = tail_miso_q;
            head_mosi_d = tail_mosi_q;
            head_cs_d   = tail_cs_q;
            fifo_cnt_d  = fifo_cnt_q - FIFO_W'(1);
         end
         2'b10: begin
            if (fifo_cnt_q == FIFO_W'(0)) begin
               head_miso_d = nxt_miso;
               head_mosi_d = nxt_mosi;
               head_cs_d   = cs_lat_q;
               fifo_cnt_d  = FIFO_W'(1);
            end else if (fifo_cnt_q == FIFO_W'(1)) begin
               tail_miso_d = nxt_miso;
               tail_mosi_d = nxt_mosi;
               tail_cs_d   = cs_lat_q;
               fifo_cnt_d  = FIFO_W'(2);
            end else begin
               overrun_d = 1'b1;
            end
         end
         2'b11: begin
            if (fifo_cnt_q == FIFO_W'(1)) begin
               head_miso_d = nxt_miso;
               head_mosi_d = nxt_mosi;
               head_cs_d   = cs_lat_q;
            end else begin
               head_miso_d = tail_miso_q;
               head_mosi_d = tail_mosi_q;
               head_cs_d   = tail_cs_q;
               tail_miso_d = nxt_miso;
               tail_mosi_d = nxt_mosi;
               tail_cs_d   = cs_lat_q;
            end
         end
         default: ;
      endcase

      valid_d = (fifo_cnt_d != FIFO_W'(0));
   end

   always_ff @(posedge pclk or negedge areset) begin
      if (!areset) begin
         state_q     <= IDLE;
         mode_q      <= CPOL0_CPHA0;
         lsb_q       <= 1'b0;
         cs_lat_q    <= CS_OFF;
         bit_cnt_q   <= '0;
         sh_miso_q   <= '0;
         sh_mosi_q   <= '0;
         settle_q    <= '0;
         armed_q     <= 1'b0;
         busy_q      <= 1'b0;
         abort_q     <= 1'b0;
         head_miso_q <= '0;
         head_mosi_q <= '0;
         head_cs_q   <= CS_OFF;
         tail_miso_q <= '0;
         tail_mosi_q <= '0;
         tail_cs_q   <= CS_OFF;
         fifo_cnt_q  <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         lsb_q       <= lsb_d;
         cs_lat_q    <= cs_lat_d;
         bit_cnt_q   <= bit_cnt_d;
         sh_miso_q   <= sh_miso_d;
         sh_mosi_q   <= sh_mosi_d;
         settle_q    <= settle_d;
         armed_q     <= armed_d;
         busy_q      <= busy_d;
         abort_q     <= abort_d;
         head_miso_q <= head_miso_d;
         head_mosi_q <= head_mosi_d;
         head_cs_q   <= head_cs_d;
         tail_miso_q <= tail_miso_d;
         tail_mosi_q <= tail_mosi_d;
         tail_cs_q   <= tail_cs_d;
         fifo_cnt_q  <= fifo_cnt_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx.rx_valid     = valid_q;
   assign rx.rx_miso_data = head_miso_q;
   assign rx.rx_mosi_data = head_mosi_q;
   assign rx.rx_cs        = head_cs_q;
   assign busy            = busy_q;
   assign overrun         = overrun_q;
   assign frame_abort     = abort_q;

endmodule

// File: tb/tb_spi_miso_deserializer.sv
// Scoreboard bench for spi_miso_deserializer: an SPI master driver, a word-level reference
// model feeding an expected queue, and an independent output monitor.
module tb_spi_miso_deserializer;

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 2;
   localparam int unsigned SS = 2;
   localparam int H = 3;

   logic          pclk = 1'b0;
   logic          areset = 1'b0;
   logic          cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
   logic          sclk = 1'b0, mosi0 = 1'b0, miso0 = 1'b0;
   logic [CW-1:0] cs = '1;
   logic          busy, overrun, frame_abort;

   always #5 pclk = ~pclk;

   spi_miso_deserializer_if #(.DATA_WIDTH(DW), .CS_WIDTH(CW)) rx_if ();

   spi_miso_deserializer #(.DATA_WIDTH(DW), .CS_WIDTH(CW), .SYNC_STAGES(SS)) dut (
      .pclk(pclk), .areset(areset), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
      .sclk(sclk), .cs(cs), .mosi0(mosi0), .miso0(miso0), .rx(rx_if),
      .busy(busy), .overrun(overrun), .frame_abort(frame_abort));

   typedef struct packed {
      logic [7:0]    mosi;
      logic [7:0]    miso;
      logic [CW-1:0] csv;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   ovr_seen = 0;
   int   abort_seen = 0;
   bit   ready_rand = 1'b0;
   bit   ready_force = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Word seen by a receiver from the wire sequence serial[7], serial[6], ...; a late launch
   // means each sample sees the previous wire bit (0 before the first).
   function automatic logic [7:0] model_word(input logic [7:0] serial, input bit lsb, input bit late);
      int v;
      bit b;
      v = 0;
      for (int i = 0; i < 8; i++) begin
         if (late) b = (i == 0) ? 1'b0 : serial[8-i];
         else      b = serial[7-i];
         v += lsb ? (int'(b) << i) : (int'(b) << (7 - i));
      end
      return 8'(v);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge pclk);
      #2;
   endtask

   task automatic set_bits(input int i, input logic [7:0] mo, input logic [7:0] mi);
      mosi0 = mo[7-i];
      miso0 = mi[7-i];
   endtask

   task automatic drive_word(input logic [7:0] mo, input logic [7:0] mi, input bit late, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            if (!late) set_bits(i, mo, mi);
            tick(H);
            sclk = ~cpol;
            if (late) begin tick(1); set_bits(i, mo, mi); tick(H - 1); end
            else tick(H);
            sclk = cpol;
         end else begin
            sclk = ~cpol;
            if (!late) set_bits(i, mo, mi);
            tick(H);
            sclk = cpol;
            if (late) begin tick(1); set_bits(i, mo, mi); tick(H - 1); end
            else tick(H);
         end
      end
   endtask

   task automatic start_frame(input logic [CW-1:0] cs_val, input bit pol, input bit pha, input bit lsb);
      cpol = pol; cpha = pha; lsb_first = lsb;
      sclk = pol; mosi0 = 1'b0; miso0 = 1'b0;
      tick(4);
      cs = cs_val;
      tick(H);
      chk("busy_active", busy, 1);
   endtask

   task automatic send_word(input logic [7:0] mo, input logic [7:0] mi, input bit late, input bit expect_word);
      exp_t e;
      if (expect_word) begin
         e.mosi = model_word(mo, lsb_first, late);
         e.miso = model_word(mi, lsb_first, late);
         e.csv  = cs;
         exp_q.push_back(e);
      end
      drive_word(mo, mi, late, 8);
   endtask

   task automatic end_frame();
      tick(H);
      cs = '1;
      tick(6);
      chk("busy_idle", busy, 0);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         tick(1);
         n++;
      end
      chk(name, exp_q.size(), 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, rx_if.rx_valid, 0);
      chk({tag, "_miso"}, rx_if.rx_miso_data, 0);
      chk({tag, "_mosi"}, rx_if.rx_mosi_data, 0);
      chk({tag, "_cs"}, rx_if.rx_cs, 2'b11);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_overrun"}, overrun, 0);
      chk({tag, "_abort"}, frame_abort, 0);
   endtask

   initial begin
      rx_if.rx_ready = 1'b0;
      forever begin
         @(posedge pclk);
         #1;
         rx_if.rx_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
      end
   end

   // Output monitor: pops the scoreboard on every handshake and watches pulse widths.
   initial begin
      exp_t e;
      bit   prev_stall, prev_ovr, prev_abort;
      logic [2*DW+CW-1:0] prev_head;
      prev_stall = 0; prev_ovr = 0; prev_abort = 0; prev_head = '0;
      forever begin
         @(negedge pclk);
         if (areset) begin
            if (prev_stall)
               chk("head_stable", {rx_if.rx_mosi_data, rx_if.rx_miso_data, rx_if.rx_cs}, prev_head);
            if (rx_if.rx_valid && rx_if.rx_ready) begin
               if (exp_q.size() == 0) chk("unexpected_word", {rx_if.rx_mosi_data, rx_if.rx_miso_data}, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("rx_mosi_data", rx_if.rx_mosi_data, e.mosi);
                  chk("rx_miso_data", rx_if.rx_miso_data, e.miso);
                  chk("rx_cs", rx_if.rx_cs, e.csv);
               end
            end
            prev_stall = rx_if.rx_valid && !rx_if.rx_ready;
            prev_head  = {rx_if.rx_mosi_data, rx_if.rx_miso_data, rx_if.rx_cs};
            if (overrun) begin ovr_seen++; chk("overrun_width", prev_ovr, 0); end
            if (frame_abort) begin abort_seen++; chk("abort_width", prev_abort, 0); end
            prev_ovr   = overrun;
            prev_abort = frame_abort;
         end else begin
            prev_stall = 0; prev_ovr = 0; prev_abort = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ovr0, ab0;
      logic [7:0] r;
      tick(3);
      chk_reset_outputs("reset");
      areset = 1'b1;
      tick(8);

      start_frame(2'b10, 0, 0, 0);
      send_word(8'hA5, 8'h3C, 0, 1);
      end_frame();

      r = 8'($urandom);
      start_frame(2'b01, 1, 1, 1);
      send_word(r, 8'h80, 0, 1);
      end_frame();
      start_frame(2'b01, 1, 1, 0);
      send_word(r, 8'h80, 0, 1);
      end_frame();

      start_frame(2'b10, 0, 1, 0);
      send_word(8'($urandom), 8'hF0, 0, 1);
      end_frame();
      start_frame(2'b10, 1, 0, 0);
      send_word(8'($urandom), 8'hF0, 0, 1);
      end_frame();
      start_frame(2'b10, 0, 1, 0);
      send_word(8'h00, 8'hF0, 1, 1);
      end_frame();
      wait_drain("drain_modes");

      ready_force = 1'b0;
      tick(2);
      ovr0 = ovr_seen;
      start_frame(2'b00, 0, 0, 0);
      send_word(8'h11, 8'hE1, 0, 1);
      send_word(8'h22, 8'hE2, 0, 1);
      send_word(8'h33, 8'hE3, 0, 0);
      end_frame();
      chk("overrun_count", ovr_seen - ovr0, 1);
      chk("full_valid", rx_if.rx_valid, 1);
      chk("full_head", rx_if.rx_mosi_data, 8'h11);
      ready_force = 1'b1;
      wait_drain("drain_overrun");

      ab0 = abort_seen;
      start_frame(2'b10, 0, 0, 0);
      drive_word(8'hFF, 8'hFF, 0, 5);
      end_frame();
      chk("abort_count", abort_seen - ab0, 1);
      chk("abort_no_valid", rx_if.rx_valid, 0);
      start_frame(2'b10, 0, 0, 0);
      send_word(8'h5A, 8'h5A, 0, 1);
      end_frame();
      wait_drain("drain_abort");

      ready_force = 1'b0;
      tick(2);
      start_frame(2'b01, 0, 0, 0);
      send_word(8'h42, 8'h24, 0, 1);
      end_frame();
      ab0 = abort_seen;
      start_frame(2'b10, 0, 0, 0);
      drive_word(8'hFF, 8'hFF, 0, 4);
      areset = 1'b0;
      exp_q.delete();
      tick(1);
      chk_reset_outputs("midreset");
      tick(2);
      areset = 1'b1;
      tick(4);
      chk("post_reset_busy", busy, 0);
      drive_word(8'hFF, 8'hFF, 0, 4);
      end_frame();
      chk("post_reset_valid", rx_if.rx_valid, 0);
      chk("post_reset_abort", abort_seen - ab0, 0);
      ready_force = 1'b1;
      start_frame(2'b10, 0, 0, 0);
      send_word(8'h81, 8'h81, 0, 1);
      end_frame();
      wait_drain("drain_reset");

      ready_rand = 1'b1;
      for (int f = 0; f < 12; f++) begin
         int nw;
         nw = int'($urandom_range(1, 2));
         start_frame(CW'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), 1'($urandom));
         for (int w = 0; w < nw; w++) send_word(8'($urandom), 8'($urandom), 0, 1);
         end_frame();
      end
      ready_rand = 1'b0;
      ready_force = 1'b1;
      wait_drain("drain_random");
      chk("total_overrun", ovr_seen, 1);
      chk("total_abort", abort_seen, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_miso_deserializer.md
# spi_miso_deserializer

Passive, synthesizable SPI capture stage that sits directly downstream of the slave driver on the serial bus. It oversamples `sclk`, `cs`, `mosi0` and `miso0` in the `pclk` domain and samples on the CPOL/CPHA-correct edge. It assembles `DATA_WIDTH`-bit words in MSB- or LSB-first order and hands paired MISO/MOSI words to a consumer through a 2-entry valid/ready buffer. It is used as the master-side receive path and as the reference capture for slave-driver checking.

## Interface
Parameters:
- `DATA_WIDTH`, 8: bits per word.
- `CS_WIDTH`, 2: number of chip selects (matches `cs_length`).
- `SYNC_STAGES`, 2: synchronizer depth on all serial inputs; legal values 2–3.

Ports:
- `pclk` in, 1: system clock.
- `areset` in, 1: asynchronous, active-low reset.
- `cpol` in, 1: clock polarity; latched at frame start.
- `cpha` in, 1: clock phase; latched at frame start.
- `lsb_first` in, 1: bit order; latched at frame start.
- `sclk` in, 1: serial clock, asynchronous to `pclk`.
- `cs` in, CS_WIDTH: active-low chip selects.
- `mosi0` in, 1: master-out line.
- `miso0` in, 1: slave-out line.
- `rx_valid` out, 1: buffer holds a word.
- `rx_ready` in, 1: consumer accepts the head word.
- `rx_miso_data` out, DATA_WIDTH: head word captured from `miso0`.
- `rx_mosi_data` out, DATA_WIDTH: head word captured from `mosi0`.
- `rx_cs` out, CS_WIDTH: `cs` value latched for the head word's frame.
- `busy` out, 1: high while a frame is active.
- `overrun` out, 1: one-cycle pulse when a completed word is dropped.
- `frame_abort` out, 1: one-cycle pulse when `cs` deasserts mid-word.

## Operation
- All four serial inputs pass through `SYNC_STAGES` flops, then one history flop. An edge is detected as synchronized value != history value.
- Sample edge: rising `sclk` when `cpol == cpha`; falling `sclk` otherwise. Both modes 0 and 3 sample on rising, modes 1 and 2 on falling.
- FSM states are IDLE and ACTIVE.
- IDLE -> ACTIVE when synchronized `cs` != all-ones.
  - On this transition, latch `cpol`, `cpha`, `lsb_first` and `cs`, and clear `bit_cnt`.
  - Config changes during ACTIVE are ignored.
- ACTIVE, on each sample edge, shifts both registers:
  - MSB-first: shift left, new bit enters bit 0, so the first bit ends at bit DATA_WIDTH-1.
  - LSB-first: shift right, new bit enters bit DATA_WIDTH-1, so the first bit ends at bit 0.
  - `bit_cnt` increments. When it reaches DATA_WIDTH-1, the shifted words plus latched `cs` are pushed and `bit_cnt` wraps to 0. Multi-word frames stay in ACTIVE.
- ACTIVE -> IDLE when synchronized `cs` returns to all-ones:
  - If `bit_cnt == 0`, exit cleanly.
  - Otherwise discard the partial word and pulse `frame_abort`.
- A `cs` deassert and a sample edge in the same cycle: the deassert wins and the edge is ignored.
- A change of `cs` to a different non-idle value during ACTIVE is treated as deassert-then-assert, passing through one IDLE cycle.
- Buffer: 2-entry FIFO. `rx_valid` = not empty. Pop on `rx_valid && rx_ready`.
  - Push when full with no pop in that cycle: drop the new word, pulse `overrun`, keep the buffer contents.
  - Push and pop in the same cycle when full: both are accepted.
- `busy` = (state == ACTIVE).

## Timing
- Reset values: `rx_valid` 0, `rx_miso_data` 0, `rx_mosi_data` 0, `rx_cs` all-ones, `busy` 0, `overrun` 0, `frame_abort` 0. The FSM enters IDLE, the FIFO is empty, `bit_cnt` is 0, and synchronizer and history flops reset to `sclk`=0, `cs`=all-ones, data=0.
- Reset asserted mid-frame: everything clears immediately. After release, no partial word or pulse is emitted. A frame already in progress is only captured once `cs` has gone idle and been reasserted.
- Latency: `sclk` last edge changing between `pclk` edges k-1 and k gives `rx_valid` high after `pclk` edge k+SYNC_STAGES.
- `busy` rises after `pclk` edge k+SYNC_STAGES for a `cs` fall before edge k.
- `frame_abort` and `overrun` are high for exactly one `pclk` cycle.
- Head data are stable while `rx_valid && !rx_ready`.
- Constraint: `sclk` period >= 4 `pclk` periods. `mosi0` and `miso0` are stable for >= 2 `pclk` cycles around the sample edge.

## Structure
- Shared package `spi_globals_pkg`:
  - `spi_mode_e` (CPOL0_CPHA0 … CPOL1_CPHA1).
  - `rx_state_e` (IDLE, ACTIVE).
  - `CS_IDLE` constant (all-ones).
- One sub-module, `spi_sync_edge`: parameterized synchronizer plus history flop. It outputs the synchronized level, `rise` and `fall`, and is instantiated once per serial input.
- The FIFO is inline: two registers plus a count.

## Test plan
- Mode 0, MSB-first, `cs`=2'b10: master sends MOSI 8'hA5, slave MISO 8'h3C -> one word `rx_mosi_data`=A5, `rx_miso_data`=3C, `rx_cs`=2'b10.
- Mode 3, LSB-first: MISO serial order 1,0,0,0,0,0,0,0 -> `rx_miso_data`=8'h01. The same sequence in MSB-first -> 8'h80.
- Modes 1 and 2: MISO 8'hF0 launched on the opposite edge -> 8'hF0 captured. A deliberately wrong-edge launch fails, proving edge selection.
- Three-word frame (11, 22, 33) with `rx_ready`=0 -> 11 and 22 buffered, `overrun` pulses once, and 33 is lost. Then `rx_ready`=1 pops 11, then 22.
- `cs` raised after 5 bits -> `frame_abort` pulse, no `rx_valid`. The next full word 8'h5A is captured correctly.
- `areset` asserted after 4 bits of 8'hFF -> all outputs return to reset values. After release, the next frame of 8'h81 is captured correctly.
